// File: rtl/u_mul_exhaustive_checker.sv
// rtl/u_mul_exhaustive_checker.sv - exhaustive operand sweep and golden-compare checker for an unsigned multiplier
// Optional build macro: MUL_CHECK_ABORT_ON_ERR_EN (stop the sweep on the first mismatch).
module u_mul_exhaustive_checker #(
  parameter int N     = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  input  logic [2*N-1:0]   mul_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [N-1:0]     first_err_a,
  output logic [N-1:0]     first_err_b
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [N-1:0]     mul_a_n, mul_b_n, first_err_a_n, first_err_b_n;
  logic [ERR_W-1:0] err_cnt_n;
  logic             first_err_valid_n, pass_n;
  logic [2*N-1:0]   golden;
  logic             mismatch, last_pair, abort_hit;

  assign golden    = (2*N)'(mul_a) * (2*N)'(mul_b);
  assign mismatch  = (mul_out != golden);
  assign last_pair = (mul_a == {N{1'b1}}) && (mul_b == {N{1'b1}});

`ifdef MUL_CHECK_ABORT_ON_ERR_EN
  assign abort_hit = mismatch && !first_err_valid;
`else
  assign abort_hit = 1'b0;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      mul_a           <= '0;
      mul_b           <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      pass            <= 1'b0;
    end else begin
      state           <= state_n;
      mul_a           <= mul_a_n;
      mul_b           <= mul_b_n;
      err_cnt         <= err_cnt_n;
      first_err_valid <= first_err_valid_n;
      first_err_a     <= first_err_a_n;
      first_err_b     <= first_err_b_n;
      pass            <= pass_n;
    end
  end

  always_comb begin
    state_n           = state;
    mul_a_n           = mul_a;
    mul_b_n           = mul_b;
    err_cnt_n         = err_cnt;
    first_err_valid_n = first_err_valid;
    first_err_a_n     = first_err_a;
    first_err_b_n     = first_err_b;
    pass_n            = pass;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n           = RUN;
          mul_a_n           = '0;
          mul_b_n           = '0;
          err_cnt_n         = '0;
          first_err_valid_n = 1'b0;
          first_err_a_n     = '0;
          first_err_b_n     = '0;
          pass_n            = 1'b0;
        end
      end
      RUN: begin
        if (mismatch) begin
          if (err_cnt != {ERR_W{1'b1}}) err_cnt_n = err_cnt + ERR_W'(1);
          if (!first_err_valid) begin
            first_err_valid_n = 1'b1;
            first_err_a_n     = mul_a;
            first_err_b_n     = mul_b;
          end
        end
        // pass is formed from the updated count so the final pair is included
        if (abort_hit) begin
          state_n = DONE;
          pass_n  = 1'b0;
        end else if (last_pair) begin
          state_n = DONE;
          pass_n  = (err_cnt_n == '0);
        end else begin
          mul_a_n = mul_a + N'(1);
          if (mul_a == {N{1'b1}}) mul_b_n = mul_b + N'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_u_mul_exhaustive_checker.sv
// tb/tb_u_mul_exhaustive_checker.sv - table-driven bench for u_mul_exhaustive_checker
module tb_u_mul_exhaustive_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] st = '0;
  logic [2:0] stuck = '0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // instance 0: N=1 ERR_W=8; instance 1: N=2 ERR_W=2; instance 2: N=2 ERR_W=8
  logic [0:0] a0, b0, fa0, fb0;
  logic [1:0] a1, b1, fa1, fb1, a2, b2, fa2, fb2;
  logic [1:0] mo0, e1;
  logic [3:0] mo1, mo2;
  logic [7:0] e0, e2;
  logic       bz0, dn0, ps0, fv0, bz1, dn1, ps1, fv1, bz2, dn2, ps2, fv2;

  assign mo0 = stuck[0] ? 2'd0 : {1'b0, a0} * {1'b0, b0};
  assign mo1 = stuck[1] ? 4'd0 : {2'b0, a1} * {2'b0, b1};
  assign mo2 = stuck[2] ? 4'd0 : {2'b0, a2} * {2'b0, b2};

  u_mul_exhaustive_checker #(.N(1), .ERR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .mul_a(a0), .mul_b(b0), .mul_out(mo0),
    .busy(bz0), .done(dn0), .pass(ps0), .err_cnt(e0), .first_err_valid(fv0),
    .first_err_a(fa0), .first_err_b(fb0));
  u_mul_exhaustive_checker #(.N(2), .ERR_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .mul_a(a1), .mul_b(b1), .mul_out(mo1),
    .busy(bz1), .done(dn1), .pass(ps1), .err_cnt(e1), .first_err_valid(fv1),
    .first_err_a(fa1), .first_err_b(fb1));
  u_mul_exhaustive_checker #(.N(2), .ERR_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .mul_a(a2), .mul_b(b2), .mul_out(mo2),
    .busy(bz2), .done(dn2), .pass(ps2), .err_cnt(e2), .first_err_valid(fv2),
    .first_err_a(fa2), .first_err_b(fb2));

  int sel = 0;
  int o_a, o_b, o_fa, o_fb, o_err;
  logic o_busy, o_done, o_pass, o_fv;

  always_comb begin
    o_a = 0; o_b = 0; o_fa = 0; o_fb = 0; o_err = 0;
    o_busy = 1'b0; o_done = 1'b0; o_pass = 1'b0; o_fv = 1'b0;
    case (sel)
      0: begin
        o_a = int'(a0); o_b = int'(b0); o_fa = int'(fa0); o_fb = int'(fb0); o_err = int'(e0);
        o_busy = bz0; o_done = dn0; o_pass = ps0; o_fv = fv0;
      end
      1: begin
        o_a = int'(a1); o_b = int'(b1); o_fa = int'(fa1); o_fb = int'(fb1); o_err = int'(e1);
        o_busy = bz1; o_done = dn1; o_pass = ps1; o_fv = fv1;
      end
      default: begin
        o_a = int'(a2); o_b = int'(b2); o_fa = int'(fa2); o_fb = int'(fb2); o_err = int'(e2);
        o_busy = bz2; o_done = dn2; o_pass = ps2; o_fv = fv2;
      end
    endcase
  end

  typedef struct {
    int s;
    logic stk;
    int cyc;
    int err;
    logic fv;
    int fa;
    int fb;
    logic pass;
    int a;
    int b;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, int'(o_busy), 0);
    check({tag, " done"}, int'(o_done), 0);
    check({tag, " pass"}, int'(o_pass), 0);
    check({tag, " err_cnt"}, o_err, 0);
    check({tag, " first_err_valid"}, int'(o_fv), 0);
    check({tag, " first_err_a"}, o_fa, 0);
    check({tag, " first_err_b"}, o_fb, 0);
    check({tag, " mul_a"}, o_a, 0);
    check({tag, " mul_b"}, o_b, 0);
  endtask

  // Pulse start for one edge, then count edges until done; repulse_at>0 re-asserts start during RUN.
  task automatic run_sweep(input int s, input int repulse_at, output int cyc);
    sel = s;
    @(negedge clk);
    st[s] = 1'b1;
    @(posedge clk);
    #1 st[s] = 1'b0;
    check("busy after start", int'(o_busy), 1);
    check("done after start", int'(o_done), 0);
    cyc = 0;
    while (!o_done && cyc < 200) begin
      if (cyc == repulse_at - 1) st[s] = 1'b1;
      @(posedge clk);
      #1 st[s] = 1'b0;
      cyc++;
    end
    if (!o_done) check("sweep timeout", cyc, -1);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{s:0, stk:1'b0, cyc:4, err:0, fv:1'b0, fa:0, fb:0, pass:1'b1, a:1, b:1};
    vecs[1] = '{s:0, stk:1'b1, cyc:4, err:1, fv:1'b1, fa:1, fb:1, pass:1'b0, a:1, b:1};
    vecs[3] = '{s:2, stk:1'b0, cyc:16, err:0, fv:1'b0, fa:0, fb:0, pass:1'b1, a:3, b:3};
`ifdef MUL_CHECK_ABORT_ON_ERR_EN
    vecs[2] = '{s:1, stk:1'b1, cyc:6, err:1, fv:1'b1, fa:1, fb:1, pass:1'b0, a:1, b:1};
    vecs[4] = '{s:2, stk:1'b1, cyc:6, err:1, fv:1'b1, fa:1, fb:1, pass:1'b0, a:1, b:1};
`else
    vecs[2] = '{s:1, stk:1'b1, cyc:16, err:3, fv:1'b1, fa:1, fb:1, pass:1'b0, a:3, b:3};
    vecs[4] = '{s:2, stk:1'b1, cyc:16, err:9, fv:1'b1, fa:1, fb:1, pass:1'b0, a:3, b:3};
`endif

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      stuck[vecs[i].s] = vecs[i].stk;
      run_sweep(vecs[i].s, 0, cyc);
      check($sformatf("v%0d cycles", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d busy", i), int'(o_busy), 0);
      check($sformatf("v%0d pass", i), int'(o_pass), int'(vecs[i].pass));
      check($sformatf("v%0d err_cnt", i), o_err, vecs[i].err);
      check($sformatf("v%0d first_err_valid", i), int'(o_fv), int'(vecs[i].fv));
      check($sformatf("v%0d first_err_a", i), o_fa, vecs[i].fa);
      check($sformatf("v%0d first_err_b", i), o_fb, vecs[i].fb);
      check($sformatf("v%0d mul_a", i), o_a, vecs[i].a);
      check($sformatf("v%0d mul_b", i), o_b, vecs[i].b);
      repeat (2) @(posedge clk);
      #1 check($sformatf("v%0d done held", i), int'(o_done), 1);
      stuck[vecs[i].s] = 1'b0;
    end

    // reset in the middle of a sweep
    sel = 2;
    @(negedge clk) st[2] = 1'b1;
    @(posedge clk);
    #1 st[2] = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("mid-sweep reset");
    @(negedge clk) rst_n = 1'b1;
    run_sweep(2, 0, cyc);
    check("post-reset cycles", cyc, 16);
    check("post-reset pass", int'(o_pass), 1);

    // start re-pulsed during RUN is ignored
    run_sweep(2, 5, cyc);
    check("repulse cycles", cyc, 16);
    check("repulse pass", int'(o_pass), 1);

    // start held high: done pulses once per sweep
    sel = 0;
    @(negedge clk) st[0] = 1'b1;
    cyc = 0;
    while (!o_done && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("held first done", int'(o_done), 1);
    @(posedge clk);
    #1 check("held done pulse", int'(o_done), 0);
    check("held rerun busy", int'(o_busy), 1);
    cyc = 0;
    while (!o_done && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("held second sweep cycles", cyc, 4);
    st[0] = 1'b0;
    @(posedge clk);
    #1 check("held release done", int'(o_done), 1);
    check("held release pass", int'(o_pass), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
